ccm_ctrl: RTL and testbench

CCM_CTRL -- requirements
Module: ccm_ctrl

---
 rtl/ccm_ctrl_pkg.sv | 28 ++
 rtl/ccm_sram.sv | 91 +++++++++
 rtl/ccm_ctrl.sv | 141 ++++++++++++++
 tb/tb_ccm_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_ctrl_pkg.sv
// ccm_ctrl_pkg
// Shared definitions for the closely-coupled memory controller: bus widths,
// the legal read-latency values, the byte-enable width, the response bundle
// returned by every memory read pipeline and the ICCM arbiter grant encoding.
// No ports; imported by ccm_sram and ccm_ctrl.
package ccm_ctrl_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // One read response as it leaves a memory pipeline.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } ccm_rsp_t;

  // Which requester owns the single ICCM access slot this cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_LOAD,
    GNT_FETCH
  } iccm_grant_e;

endpackage

// File: rtl/ccm_sram.sv
// ccm_sram
// Single-port word memory with byte writes and a registered read pipeline of
// RD_LAT stages (1 or 2). Addresses are byte addresses; the low two bits are
// ignored and any word offset at or beyond WORDS is out of range. Out-of-range
// writes are dropped, out-of-range reads answer at normal latency with err=1
// and rdata=0. Reset clears the pipeline only, never the array.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_req            access accepted this cycle (handshake already done)
//   i_we, i_be       write flag and byte enables
//   i_addr, i_wdata  byte address and write data
//   o_rsp            read response (valid, rdata, err)
module ccm_sram
  import ccm_ctrl_pkg::*;
#(
  parameter int unsigned WORDS  = 4096,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output ccm_rsp_t          o_rsp
);

  localparam int unsigned IDX_W = $clog2(WORDS);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [IDX_W-1:0]  w_idx;
  logic              w_inRange;
  logic              w_wrEn;
  logic              w_rdEn;
  logic [1:0]        w_unusedAddrBits;
  ccm_rsp_t          r_s1;

  // Address decode: the word index comes straight from the address bits
  // above the byte offset, and anything set above the index is past the end.
  always_comb begin
    w_idx            = i_addr[IDX_W+1:2];
    w_inRange        = (i_addr[ADDR_W-1:IDX_W+2] == '0);
    w_wrEn           = i_req & i_we & w_inRange;
    w_rdEn           = i_req & ~i_we;
    w_unusedAddrBits = i_addr[1:0];
  end

  // Byte-lane writes into the array. No reset here so contents survive it.
  always_ff @(posedge i_clk) begin
    if (w_wrEn) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // First read stage. The array is read after any write of the previous
  // cycle has landed, so a read right behind a write sees the new data.
  // rdata stays zero whenever there is no in-range read to report.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
    end else begin
      r_s1.valid <= w_rdEn;
      r_s1.err   <= w_rdEn & ~w_inRange;
      r_s1.rdata <= (w_rdEn && w_inRange) ? r_mem[w_idx] : '0;
    end
  end

  // Optional second output stage for the two-cycle configuration.
  if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
    ccm_rsp_t r_s2;

    // Plain retiming register, cleared by reset so in-flight reads die.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_s2 <= '0;
      end else begin
        r_s2 <= r_s1;
      end
    end

    assign o_rsp = r_s2;
  end else begin : g_lat1
    assign o_rsp = r_s1;
  end

endmodule

// File: rtl/ccm_ctrl.sv
// ccm_ctrl
// Closely-coupled memory controller: a DCCM with byte-write loads/stores and
// an ICCM shared between an instruction fetch port and a full-word program
// load port. Load normally wins the ICCM slot, but after LOAD_MAX_BURST
// back-to-back load grants with a fetch waiting the fetch gets one cycle.
// Ports:
//   i_clk, i_rst_n                       clock, synchronous active-low reset
//   i_dccm_req_*/o_dccm_req_ready        DCCM request (we, be, addr, wdata)
//   o_dccm_rsp_valid/rdata/err           DCCM read response
//   i_iccm_req_valid/addr/o_iccm_req_ready  instruction fetch request
//   o_iccm_rsp_valid/rdata/err           fetch response
//   i_load_valid/addr/wdata/o_load_ready ICCM program-load write
module ccm_ctrl
  import ccm_ctrl_pkg::*;
#(
  parameter int unsigned DCCM_WORDS     = 4096,
  parameter int unsigned ICCM_WORDS     = 8192,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned LOAD_MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dccm_req_valid,
  output logic              o_dccm_req_ready,
  input  logic              i_dccm_req_we,
  input  logic [BE_W-1:0]   i_dccm_req_be,
  input  logic [ADDR_W-1:0] i_dccm_req_addr,
  input  logic [DATA_W-1:0] i_dccm_req_wdata,
  output logic              o_dccm_rsp_valid,
  output logic [DATA_W-1:0] o_dccm_rsp_rdata,
  output logic              o_dccm_rsp_err,
  input  logic              i_iccm_req_valid,
  output logic              o_iccm_req_ready,
  input  logic [ADDR_W-1:0] i_iccm_req_addr,
  output logic              o_iccm_rsp_valid,
  output logic [DATA_W-1:0] o_iccm_rsp_rdata,
  output logic              o_iccm_rsp_err,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_wdata
);

  localparam int unsigned CNT_W = $clog2(LOAD_MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LOAD_MAX_BURST);

  logic [CNT_W-1:0]  r_burstCount;
  logic              w_burstFull;
  iccm_grant_e       w_iccmGrant;
  logic              w_dccmAccept;
  logic              w_iccmReq;
  logic              w_iccmWe;
  logic [ADDR_W-1:0] w_iccmAddr;
  ccm_rsp_t          w_dccmRsp;
  ccm_rsp_t          w_iccmRsp;

  // DCCM is always ready outside reset; holding ready low during reset is
  // what keeps requests from being accepted while the pipeline is cleared.
  always_comb begin
    o_dccm_req_ready = i_rst_n;
    w_dccmAccept     = i_dccm_req_valid & o_dccm_req_ready;
  end

  // ICCM arbitration. Each ready says whether that port would win if it
  // asked, so an idle port still shows ready when nothing would beat it.
  // Fetch only beats a pending load once the burst counter is full, which
  // makes the two readies mutually exclusive when both ports are valid.
  always_comb begin
    w_burstFull      = (r_burstCount == BURST_MAX);
    o_load_ready     = i_rst_n & ~(i_iccm_req_valid & w_burstFull);
    o_iccm_req_ready = i_rst_n & (~i_load_valid | w_burstFull);
    w_iccmGrant      = GNT_NONE;
    if (i_load_valid && o_load_ready) begin
      w_iccmGrant = GNT_LOAD;
    end else if (i_iccm_req_valid && o_iccm_req_ready) begin
      w_iccmGrant = GNT_FETCH;
    end
  end

  // Burst counter: counts load grants that made a fetch wait. It drops to
  // zero on a fetch grant, on any cycle without a load request, and on a
  // load grant nobody was waiting behind, since no starvation is building.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_burstCount <= '0;
    end else if (w_iccmGrant == GNT_FETCH || !i_load_valid) begin
      r_burstCount <= '0;
    end else if (w_iccmGrant == GNT_LOAD && i_iccm_req_valid) begin
      r_burstCount <= r_burstCount + 1'b1;
    end else begin
      r_burstCount <= '0;
    end
  end

  // Steer the winning requester onto the single ICCM port. Loads are
  // always full-word writes, fetches are always reads.
  always_comb begin
    w_iccmReq  = (w_iccmGrant != GNT_NONE);
    w_iccmWe   = (w_iccmGrant == GNT_LOAD);
    w_iccmAddr = (w_iccmGrant == GNT_LOAD) ? i_load_addr : i_iccm_req_addr;
  end

  ccm_sram #(
    .WORDS  (DCCM_WORDS),
    .RD_LAT (RD_LAT)
  ) u_dccm (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (w_dccmAccept),
    .i_we    (i_dccm_req_we),
    .i_be    (i_dccm_req_be),
    .i_addr  (i_dccm_req_addr),
    .i_wdata (i_dccm_req_wdata),
    .o_rsp   (w_dccmRsp)
  );

  ccm_sram #(
    .WORDS  (ICCM_WORDS),
    .RD_LAT (RD_LAT)
  ) u_iccm (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (w_iccmReq),
    .i_we    (w_iccmWe),
    .i_be    ({BE_W{1'b1}}),
    .i_addr  (w_iccmAddr),
    .i_wdata (i_load_wdata),
    .o_rsp   (w_iccmRsp)
  );

  // Unpack the response bundles onto the flat output ports.
  always_comb begin
    o_dccm_rsp_valid = w_dccmRsp.valid;
    o_dccm_rsp_rdata = w_dccmRsp.rdata;
    o_dccm_rsp_err   = w_dccmRsp.err;
    o_iccm_rsp_valid = w_iccmRsp.valid;
    o_iccm_rsp_rdata = w_iccmRsp.rdata;
    o_iccm_rsp_err   = w_iccmRsp.err;
  end

endmodule

// File: tb/tb_ccm_ctrl.sv
// tb_ccm_ctrl
// Directed bench for ccm_ctrl. The main instance runs with two-cycle reads;
// a second instance with single-cycle reads shares every input so its DCCM
// response timing can be checked alongside.
module tb_ccm_ctrl;

  localparam int unsigned DW = 256;
  localparam int unsigned IW = 512;

  logic        clk = 1'b0;
  logic        rstN;
  logic        dccmReqValid;
  logic        dccmReqWe;
  logic [3:0]  dccmReqBe;
  logic [31:0] dccmReqAddr;
  logic [31:0] dccmReqWdata;
  logic        iccmReqValid;
  logic [31:0] iccmReqAddr;
  logic        loadValid;
  logic [31:0] loadAddr;
  logic [31:0] loadWdata;

  logic        dccmReqReady, dccmRspValid, dccmRspErr;
  logic [31:0] dccmRspRdata;
  logic        iccmReqReady, iccmRspValid, iccmRspErr;
  logic [31:0] iccmRspRdata;
  logic        loadReady;

  logic        fDccmReqReady, fDccmRspValid, fDccmRspErr;
  logic [31:0] fDccmRspRdata;
  logic        fIccmReqReady, fIccmRspValid, fIccmRspErr;
  logic [31:0] fIccmRspRdata;
  logic        fLoadReady;

  int checks = 0;
  int errors = 0;

  logic [31:0] rdData;
  logic [31:0] fastData;
  logic        rdErr;
  logic        fastValid;
  int          rdLat;

  always #5 clk = ~clk;

  ccm_ctrl #(
    .DCCM_WORDS(DW), .ICCM_WORDS(IW), .RD_LAT(2), .LOAD_MAX_BURST(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_dccm_req_valid(dccmReqValid), .o_dccm_req_ready(dccmReqReady),
    .i_dccm_req_we(dccmReqWe), .i_dccm_req_be(dccmReqBe),
    .i_dccm_req_addr(dccmReqAddr), .i_dccm_req_wdata(dccmReqWdata),
    .o_dccm_rsp_valid(dccmRspValid), .o_dccm_rsp_rdata(dccmRspRdata),
    .o_dccm_rsp_err(dccmRspErr),
    .i_iccm_req_valid(iccmReqValid), .o_iccm_req_ready(iccmReqReady),
    .i_iccm_req_addr(iccmReqAddr),
    .o_iccm_rsp_valid(iccmRspValid), .o_iccm_rsp_rdata(iccmRspRdata),
    .o_iccm_rsp_err(iccmRspErr),
    .i_load_valid(loadValid), .o_load_ready(loadReady),
    .i_load_addr(loadAddr), .i_load_wdata(loadWdata)
  );

  ccm_ctrl #(
    .DCCM_WORDS(DW), .ICCM_WORDS(IW), .RD_LAT(1), .LOAD_MAX_BURST(4)
  ) dutFast (
    .i_clk(clk), .i_rst_n(rstN),
    .i_dccm_req_valid(dccmReqValid), .o_dccm_req_ready(fDccmReqReady),
    .i_dccm_req_we(dccmReqWe), .i_dccm_req_be(dccmReqBe),
    .i_dccm_req_addr(dccmReqAddr), .i_dccm_req_wdata(dccmReqWdata),
    .o_dccm_rsp_valid(fDccmRspValid), .o_dccm_rsp_rdata(fDccmRspRdata),
    .o_dccm_rsp_err(fDccmRspErr),
    .i_iccm_req_valid(iccmReqValid), .o_iccm_req_ready(fIccmReqReady),
    .i_iccm_req_addr(iccmReqAddr),
    .o_iccm_rsp_valid(fIccmRspValid), .o_iccm_rsp_rdata(fIccmRspRdata),
    .o_iccm_rsp_err(fIccmRspErr),
    .i_load_valid(loadValid), .o_load_ready(fLoadReady),
    .i_load_addr(loadAddr), .i_load_wdata(loadWdata)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single DCCM write, accepted on the next edge.
  task automatic dccmWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    dccmReqValid = 1'b1;
    dccmReqWe    = 1'b1;
    dccmReqBe    = be;
    dccmReqAddr  = addr;
    dccmReqWdata = data;
    tick();
    dccmReqValid = 1'b0;
    dccmReqWe    = 1'b0;
  endtask

  // Single DCCM read; returns the slow instance's response and the number
  // of cycles after acceptance it took (6 means it never came).
  task automatic dccmRead(input logic [31:0] addr, output logic [31:0] data,
                          output logic err, output int lat,
                          output logic fValid, output logic [31:0] fData);
    dccmReqValid = 1'b1;
    dccmReqWe    = 1'b0;
    dccmReqBe    = 4'h0;
    dccmReqAddr  = addr;
    tick();
    dccmReqValid = 1'b0;
    fValid = fDccmRspValid;
    fData  = fDccmRspRdata;
    lat = 1;
    while (dccmRspValid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    data = dccmRspRdata;
    err  = dccmRspErr;
  endtask

  // Single ICCM fetch with the load port idle.
  task automatic iccmFetch(input logic [31:0] addr, output logic [31:0] data,
                           output logic err, output int lat);
    iccmReqValid = 1'b1;
    iccmReqAddr  = addr;
    tick();
    iccmReqValid = 1'b0;
    lat = 1;
    while (iccmRspValid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    data = iccmRspRdata;
    err  = iccmRspErr;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    dccmReqValid = 1'b1;
    dccmReqAddr  = 32'h0;
    tick();
    tick();
    checks++;
    if (dccmReqReady !== 1'b0 || iccmReqReady !== 1'b0 || loadReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got dccm=%b iccm=%b load=%b expected 0,0,0",
               dccmReqReady, iccmReqReady, loadReady);
    end
    checks++;
    if (dccmRspValid !== 1'b0 || dccmRspErr !== 1'b0 || dccmRspRdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_dccm_rsp: got v=%b e=%b d=%h expected 0,0,0",
               dccmRspValid, dccmRspErr, dccmRspRdata);
    end
    checks++;
    if (iccmRspValid !== 1'b0 || iccmRspErr !== 1'b0 || iccmRspRdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_iccm_rsp: got v=%b e=%b d=%h expected 0,0,0",
               iccmRspValid, iccmRspErr, iccmRspRdata);
    end
    dccmReqValid = 1'b0;
    rstN = 1'b1;
    #1;
    checks++;
    if (dccmReqReady !== 1'b1 || iccmReqReady !== 1'b1 || loadReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready: got dccm=%b iccm=%b load=%b expected 1,1,1",
               dccmReqReady, iccmReqReady, loadReady);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dccmRspValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_accept: got valid=%b expected 0", dccmRspValid);
      end
    end
  endtask

  task automatic test_rd_lat();
    dccmWrite(32'h40, 32'hDEADBEEF, 4'hF);
    dccmRead(32'h40, rdData, rdErr, rdLat, fastValid, fastData);
    checks++;
    if (rdLat != 2 || rdData !== 32'hDEADBEEF || rdErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL raw_lat2: got lat=%0d d=%h e=%b expected lat=2 d=deadbeef e=0",
               rdLat, rdData, rdErr);
    end
    checks++;
    if (fastValid !== 1'b1 || fastData !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL raw_lat1: got v=%b d=%h expected v=1 d=deadbeef",
               fastValid, fastData);
    end
    tick();
    checks++;
    if (dccmRspValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rsp_one_cycle: got valid=%b expected 0", dccmRspValid);
    end
  endtask

  task automatic test_byte_enable();
    dccmWrite(32'h80, 32'h11223344, 4'hF);
    dccmWrite(32'h80, 32'h0000AA00, 4'b0010);
    dccmRead(32'h80, rdData, rdErr, rdLat, fastValid, fastData);
    checks++;
    if (rdData !== 32'h1122AA44 || rdLat != 2) begin
      errors++;
      $display("[TB] FAIL byte_enable: got d=%h lat=%0d expected 1122aa44 lat=2",
               rdData, rdLat);
    end
    tick();
    dccmWrite(32'h80, 32'hFFFFFFFF, 4'h0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dccmRspValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL be0_no_rsp: got valid=%b expected 0", dccmRspValid);
      end
      tick();
    end
    dccmRead(32'h83, rdData, rdErr, rdLat, fastValid, fastData);
    checks++;
    if (rdData !== 32'h1122AA44 || rdErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL be0_noop_lowbits: got d=%h e=%b expected 1122aa44 e=0",
               rdData, rdErr);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    dccmWrite(32'h0, 32'hCAFEF00D, 4'hF);
    dccmRead(DW * 4, rdData, rdErr, rdLat, fastValid, fastData);
    checks++;
    if (rdErr !== 1'b1 || rdData !== 32'h0 || rdLat != 2) begin
      errors++;
      $display("[TB] FAIL oor_read: got e=%b d=%h lat=%0d expected e=1 d=0 lat=2",
               rdErr, rdData, rdLat);
    end
    tick();
    dccmWrite(DW * 4, 32'h12345678, 4'hF);
    dccmRead(32'h0, rdData, rdErr, rdLat, fastValid, fastData);
    checks++;
    if (rdData !== 32'hCAFEF00D || rdErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_write_dropped: got d=%h e=%b expected cafef00d e=0",
               rdData, rdErr);
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic expLoad;
    int   loadIdx;
    loadValid = 1'b1;
    loadAddr  = 32'h0;
    loadWdata = 32'hA0000000;
    #1;
    checks++;
    if (loadReady !== 1'b1 || iccmReqReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_fetch_ready: got load=%b fetch=%b expected 1,0",
               loadReady, iccmReqReady);
    end
    iccmReqValid = 1'b1;
    iccmReqAddr  = 32'h0;
    loadIdx = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      expLoad = (c % 5 != 4);
      checks++;
      if (loadReady !== expLoad || iccmReqReady !== !expLoad) begin
        errors++;
        $display("[TB] FAIL grant_c%0d: got load=%b fetch=%b expected load=%b fetch=%b",
                 c, loadReady, iccmReqReady, expLoad, !expLoad);
      end
      tick();
      if (expLoad) begin
        loadIdx++;
        loadAddr  = loadIdx * 4;
        loadWdata = 32'hA0000000 + loadIdx;
      end
    end
    loadValid    = 1'b0;
    iccmReqValid = 1'b0;
    tick();
    tick();
    tick();
    iccmFetch(32'h14, rdData, rdErr, rdLat);
    checks++;
    if (rdData !== 32'hA0000005 || rdErr !== 1'b0 || rdLat != 2) begin
      errors++;
      $display("[TB] FAIL fetch_w5: got d=%h e=%b lat=%0d expected a0000005 e=0 lat=2",
               rdData, rdErr, rdLat);
    end
    iccmFetch(32'h1C, rdData, rdErr, rdLat);
    checks++;
    if (rdData !== 32'hA0000007) begin
      errors++;
      $display("[TB] FAIL fetch_w7: got d=%h expected a0000007", rdData);
    end
    loadValid = 1'b1;
    loadAddr  = IW * 4;
    loadWdata = 32'hFFFFFFFF;
    tick();
    loadValid = 1'b0;
    iccmFetch(32'h0, rdData, rdErr, rdLat);
    checks++;
    if (rdData !== 32'hA0000000 || rdErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_load_dropped: got d=%h e=%b expected a0000000 e=0",
               rdData, rdErr);
    end
    iccmFetch(IW * 4, rdData, rdErr, rdLat);
    checks++;
    if (rdErr !== 1'b1 || rdData !== 32'h0 || rdLat != 2) begin
      errors++;
      $display("[TB] FAIL oor_fetch: got e=%b d=%h lat=%0d expected e=1 d=0 lat=2",
               rdErr, rdData, rdLat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic expValid;
    logic expFast;
    for (int i = 0; i < 8; i++) begin
      dccmWrite(32'h100 + i * 4, 32'h5000 + i, 4'hF);
    end
    tick();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        dccmReqValid = 1'b1;
        dccmReqWe    = 1'b0;
        dccmReqAddr  = 32'h100 + c * 4;
      end else begin
        dccmReqValid = 1'b0;
      end
      tick();
      expValid = (c >= 1 && c <= 8);
      expFast  = (c <= 7);
      checks++;
      if (dccmRspValid !== expValid ||
          (expValid && dccmRspRdata !== 32'h5000 + (c - 1))) begin
        errors++;
        $display("[TB] FAIL b2b_lat2_c%0d: got v=%b d=%h expected v=%b d=%h",
                 c, dccmRspValid, dccmRspRdata, expValid, 32'h5000 + (c - 1));
      end
      checks++;
      if (fDccmRspValid !== expFast ||
          (expFast && fDccmRspRdata !== 32'h5000 + c)) begin
        errors++;
        $display("[TB] FAIL b2b_lat1_c%0d: got v=%b d=%h expected v=%b d=%h",
                 c, fDccmRspValid, fDccmRspRdata, expFast, 32'h5000 + c);
      end
    end
  endtask

  task automatic test_reset_kill();
    dccmReqValid = 1'b1;
    dccmReqWe    = 1'b0;
    dccmReqAddr  = 32'h100;
    tick();
    dccmReqAddr  = 32'h104;
    tick();
    dccmReqValid = 1'b0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dccmRspValid !== 1'b0 || fDccmRspValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_kill_k%0d: got slow=%b fast=%b expected 0,0",
                 k, dccmRspValid, fDccmRspValid);
      end
      tick();
    end
    dccmRead(32'h104, rdData, rdErr, rdLat, fastValid, fastData);
    checks++;
    if (rdData !== 32'h5001 || rdLat != 2) begin
      errors++;
      $display("[TB] FAIL mem_preserved: got d=%h lat=%0d expected 00005001 lat=2",
               rdData, rdLat);
    end
    tick();
  endtask

  // Main sequence.
  initial begin
    rstN         = 1'b0;
    dccmReqValid = 1'b0;
    dccmReqWe    = 1'b0;
    dccmReqBe    = 4'h0;
    dccmReqAddr  = 32'h0;
    dccmReqWdata = 32'h0;
    iccmReqValid = 1'b0;
    iccmReqAddr  = 32'h0;
    loadValid    = 1'b0;
    loadAddr     = 32'h0;
    loadWdata    = 32'h0;
    test_reset();
    test_rd_lat();
    test_byte_enable();
    test_out_of_range();
    test_arbitration();
    test_back_to_back();
    test_reset_kill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
